uart_autobaud: RTL and testbench

Auto-baud controller that configures the UART baud-rate generator at run time. On request it measures a received sync character (0x55) on the serial line, derives the divisor the baud generator needs for its oversampling tick, and presents it with a valid flag. It sits between the RX pin and the divisor input of the baud generator. The RX and TX engines keep using the generator's tick unchanged.

---
 rtl/uart_autobaud_pkg.sv | 20 ++
 rtl/uart_autobaud_rx_sync.sv | 30 +++
 rtl/uart_autobaud.sv | 172 +++++++++++++++++
 tb/tb_uart_autobaud.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_autobaud_pkg.sv
// Shared definitions for the auto-baud controller: FSM encoding, sizing helpers, sync character.
package uart_autobaud_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitIdle,
    StWaitStart,
    StMeasure,
    StCheck
  } state_e;

  // Character the remote end sends for measurement; its falling edges are 2 bit times apart.
  localparam logic [7:0] SYNC_CHAR = 8'h55;

  // Fractional bits of the measured 8-bit-time count: 3 for the 8 bits, plus log2(OVERSAMPLE).
  function automatic int unsigned calc_s(input int unsigned oversample);
    return 3 + $clog2(oversample);
  endfunction

endpackage

// File: rtl/uart_autobaud_rx_sync.sv
// Two-flop synchronizer for the raw RX line plus a falling-edge detector; all flops idle high.
module uart_rx_sync (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic rx_i,
  output logic rx_o,
  output logic fall_o
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronizer chain and one-cycle history for edge detection.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= rx_i;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign rx_o   = r_sync;
  assign fall_o = r_prev & ~r_sync;

endmodule

// File: rtl/uart_autobaud.sv
// Auto-baud controller: times four 0x55 falling-edge intervals and derives the baud divisor.
module uart_autobaud
  import uart_autobaud_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned DEF_DIV    = 1,
  parameter int unsigned MIN_IDLE   = 64
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             rx_i,
  input  logic             start_i,
  input  logic             abort_i,
  output logic [DIV_W-1:0] divisor_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o
);

  localparam int unsigned S     = calc_s(OVERSAMPLE);
  localparam int unsigned CNT_W = DIV_W + S;
  localparam int unsigned XW    = CNT_W + 2;
  localparam int unsigned IW    = (MIN_IDLE > 1) ? $clog2(MIN_IDLE) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(MIN_IDLE - 1);

  state_e           r_state, w_state_next;
  logic [IW-1:0]    r_idle, w_idle_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next, w_cnt_inc;
  logic [CNT_W-1:0] r_t2, w_t2_next;
  logic [CNT_W-1:0] r_t8, w_t8_next;
  logic [2:0]       r_edges, w_edges_next, w_edges_inc;
  logic [DIV_W-1:0] r_div, w_div_next;
  logic             r_valid, w_valid_next;
  logic             r_done, w_done_next;
  logic             r_error, w_error_next;

  logic             w_rx;
  logic             w_fall;

  logic [XW-1:0]    w_t8x, w_t2x4, w_sum, w_d, w_diff, w_tol;
  logic             w_chk_ok;

  uart_rx_sync u_rx_sync (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .rx_i     (rx_i),
    .rx_o     (w_rx),
    .fall_o   (w_fall)
  );

  // Saturating cycle counter; latching the incremented value counts the edge cycle itself.
  assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_edges_inc = r_edges + 3'd1;

  // Rounded divisor and consistency between the 2-bit and 8-bit interval measurements.
  assign w_t8x    = {2'b00, r_t8};
  assign w_t2x4   = {r_t2, 2'b00};
  assign w_sum    = w_t8x + (XW'(1) << (S - 1));
  assign w_d      = w_sum >> S;
  assign w_diff   = (w_t8x >= w_t2x4) ? (w_t8x - w_t2x4) : (w_t2x4 - w_t8x);
  assign w_tol    = w_t8x >> 2;
  assign w_chk_ok = (w_d != '0) && (w_d[XW-1:DIV_W] == '0) && (w_diff <= w_tol);

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= StIdle;
      r_idle  <= '0;
      r_cnt   <= '0;
      r_t2    <= '0;
      r_t8    <= '0;
      r_edges <= '0;
      r_div   <= DIV_W'(DEF_DIV);
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idle  <= w_idle_next;
      r_cnt   <= w_cnt_next;
      r_t2    <= w_t2_next;
      r_t8    <= w_t8_next;
      r_edges <= w_edges_next;
      r_div   <= w_div_next;
      r_valid <= w_valid_next;
      r_done  <= w_done_next;
      r_error <= w_error_next;
    end
  end

  // Next-state logic; abort beats every other event outside IDLE.
  always_comb begin
    w_state_next = r_state;
    w_idle_next  = r_idle;
    w_cnt_next   = r_cnt;
    w_t2_next    = r_t2;
    w_t8_next    = r_t8;
    w_edges_next = r_edges;
    w_div_next   = r_div;
    w_valid_next = r_valid;
    w_done_next  = 1'b0;
    w_error_next = 1'b0;

    if ((r_state != StIdle) && abort_i) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start_i) begin
            w_state_next = StWaitIdle;
            w_idle_next  = '0;
          end
        end
        StWaitIdle: begin
          if (!w_rx) begin
            w_idle_next = '0;
          end else if (r_idle == IDLE_LAST) begin
            w_state_next = StWaitStart;
          end else begin
            w_idle_next = r_idle + IW'(1);
          end
        end
        StWaitStart: begin
          if (w_fall) begin
            w_cnt_next   = '0;
            w_edges_next = '0;
            w_state_next = StMeasure;
          end
        end
        StMeasure: begin
          w_cnt_next = w_cnt_inc;
          if (&r_cnt) begin
            w_error_next = 1'b1;
            w_state_next = StIdle;
          end else if (w_fall) begin
            w_edges_next = w_edges_inc;
            if (w_edges_inc == 3'd1) begin
              w_t2_next = w_cnt_inc;
            end
            if (w_edges_inc == 3'd4) begin
              w_t8_next    = w_cnt_inc;
              w_state_next = StCheck;
            end
          end
        end
        StCheck: begin
          if (w_chk_ok) begin
            w_div_next   = w_d[DIV_W-1:0];
            w_valid_next = 1'b1;
            w_done_next  = 1'b1;
          end else begin
            w_error_next = 1'b1;
          end
          w_state_next = StIdle;
        end
        default: begin
          w_state_next = StIdle;
        end
      endcase
    end
  end

  assign divisor_o = r_div;
  assign valid_o   = r_valid;
  assign done_o    = r_done;
  assign error_o   = r_error;
  // Result pulse is registered, so keep busy high through the cycle it is visible.
  assign busy_o    = (r_state != StIdle) | r_done | r_error;

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: measurement, consistency failure, timeout, abort, reset.
module tb_uart_autobaud;
  import uart_autobaud_pkg::*;

  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic        rx = 1'b1, start = 1'b0, abort = 1'b0;
  logic [15:0] divisor;
  logic        valid, busy, done, err;

  // Narrow instance so the counter saturates within a short run.
  logic        rx2 = 1'b1, start2 = 1'b0, abort2 = 1'b0;
  logic [3:0]  divisor2;
  logic        valid2, busy2, done2, err2;

  int n_total = 0, n_pass = 0, n_fail = 0;
  int n_done = 0, n_err = 0, n_both = 0, n_done2 = 0, n_err2 = 0;
  logic prev_done = 1'b0, busy_after_done = 1'bx;
  int base_d, base_e;

  always #5 clk = ~clk;

  uart_autobaud u_dut (
    .clk_i(clk), .reset_ni(reset_ni), .rx_i(rx), .start_i(start), .abort_i(abort),
    .divisor_o(divisor), .valid_o(valid), .busy_o(busy), .done_o(done), .error_o(err)
  );

  uart_autobaud #(.DIV_W(4), .MIN_IDLE(8)) u_dut_small (
    .clk_i(clk), .reset_ni(reset_ni), .rx_i(rx2), .start_i(start2), .abort_i(abort2),
    .divisor_o(divisor2), .valid_o(valid2), .busy_o(busy2), .done_o(done2), .error_o(err2)
  );

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (done) n_done++;
    if (err) n_err++;
    if (done && err) n_both++;
    if (prev_done) busy_after_done = busy;
    prev_done = done;
    if (done2) n_done2++;
    if (err2) n_err2++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  // Frame = start bit, 8 data bits LSB first, stop bit. Frame bits 0/1 last len01 cycles each.
  task automatic send_frame(input logic [7:0] data, input int len01, input int len,
                            input int restart_bit);
    logic [9:0] fr;
    int         dur;
    fr = {1'b1, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx  = fr[i];
      dur = (i < 2) ? len01 : len;
      if (i == restart_bit) begin
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(dur - 1);
      end else begin
        cycles(dur);
      end
    end
  endtask

  initial begin
    // Reset with a noisy line.
    for (int i = 0; i < 8; i++) begin
      rx = 1'($urandom_range(0, 1));
      cycles(1);
    end
    check("rst_valid", valid, 0);
    check("rst_divisor", divisor, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", err, 0);
    rx = 1'b1;
    cycles(2);
    reset_ni = 1'b1;
    cycles(4);

    // 160 cycles/bit: t8 = 1280, d = (1280 + 64) >> 7 = 10.
    base_d = n_done; base_e = n_err;
    pulse_start();
    check("busy_after_start", busy, 1);
    cycles(100);
    send_frame(SYNC_CHAR, 160, 160, -1);
    cycles(20);
    check("b160_done_cnt", n_done - base_d, 1);
    check("b160_err_cnt", n_err - base_e, 0);
    check("b160_divisor", divisor, 10);
    check("b160_valid", valid, 1);
    check("b160_busy_idle", busy, 0);

    // 868 cycles/bit: t8 = 6944, d = 7008 >> 7 = 54. A start mid-frame must be ignored.
    base_d = n_done; base_e = n_err;
    pulse_start();
    cycles(100);
    send_frame(SYNC_CHAR, 868, 868, 4);
    cycles(20);
    check("b868_done_cnt", n_done - base_d, 1);
    check("b868_err_cnt", n_err - base_e, 0);
    check("b868_divisor", divisor, 54);
    check("b868_busy_after_done", busy_after_done, 0);
    check("no_done_and_error", n_both, 0);

    // First bit pair 480 cycles, rest 160: t2 = 480, t8 = 1440, |1440 - 1920| = 480 > 360.
    base_d = n_done; base_e = n_err;
    pulse_start();
    cycles(100);
    send_frame(SYNC_CHAR, 240, 160, -1);
    cycles(20);
    check("skew_err_cnt", n_err - base_e, 1);
    check("skew_done_cnt", n_done - base_d, 0);
    check("skew_divisor_kept", divisor, 54);
    check("skew_valid_kept", valid, 1);

    // Abort during MEASURE.
    base_d = n_done; base_e = n_err;
    pulse_start();
    cycles(100);
    rx = 1'b0;
    cycles(50);
    check("abort_busy_before", busy, 1);
    abort = 1'b1;
    cycles(1);
    abort = 1'b0;
    check("abort_busy_next", busy, 0);
    rx = 1'b1;
    cycles(300);
    check("abort_no_pulse", (n_done - base_d) + (n_err - base_e), 0);
    check("abort_divisor_kept", divisor, 54);
    check("abort_valid_kept", valid, 1);

    // Reset during MEASURE: outputs drop immediately, no pulse afterwards.
    base_d = n_done; base_e = n_err;
    pulse_start();
    cycles(100);
    rx = 1'b0;
    cycles(50);
    reset_ni = 1'b0;
    #2;
    check("mrst_valid", valid, 0);
    check("mrst_divisor", divisor, 1);
    check("mrst_busy", busy, 0);
    rx = 1'b1;
    cycles(3);
    reset_ni = 1'b1;
    cycles(200);
    check("mrst_no_pulse", (n_done - base_d) + (n_err - base_e), 0);

    // Timeout on the narrow instance: CNT_W = 11, counter saturates after ~2048 cycles.
    base_d = n_done2; base_e = n_err2;
    start2 = 1'b1;
    cycles(1);
    start2 = 1'b0;
    cycles(20);
    rx2 = 1'b0;
    cycles(2000);
    check("tmo_busy_running", busy2, 1);
    check("tmo_no_early_err", n_err2 - base_e, 0);
    cycles(200);
    check("tmo_err_cnt", n_err2 - base_e, 1);
    check("tmo_done_cnt", n_done2 - base_d, 0);
    check("tmo_busy_idle", busy2, 0);
    check("tmo_valid", valid2, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
